// File: rtl/icache_direct_mapped_if.sv
`default_nettype none
// ============================================================================
// Module   : icache_direct_mapped_if
// Purpose  : IFU fetch port, arbiter refill port and counters of the I-cache.
// Revision : 1.0
// ============================================================================
interface icache_direct_mapped_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_req;
    logic [DATA_W-1:0] ifu_rdata;
    logic              ifu_rvalid;
    logic              flush;
    logic [ADDR_W-1:0] bus_araddr;
    logic              bus_arvalid;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_rvalid;
    logic [31:0]       hit_cnt;
    logic [31:0]       miss_cnt;

    // The cache side.
    modport slave (
        input  ifu_addr, ifu_req, flush, bus_rdata, bus_rvalid,
        output ifu_rdata, ifu_rvalid, bus_araddr, bus_arvalid, hit_cnt, miss_cnt
    );

    // The IFU / arbiter side.
    modport master (
        output ifu_addr, ifu_req, flush, bus_rdata, bus_rvalid,
        input  ifu_rdata, ifu_rvalid, bus_araddr, bus_arvalid, hit_cnt, miss_cnt
    );
endinterface
`default_nettype wire

// File: rtl/icache_direct_mapped.sv
`default_nettype none
// ============================================================================
// Module   : icache_direct_mapped
// Purpose  : Direct-mapped read-only I-cache, critical-word-first wrapping refill.
// Revision : 1.0
// ============================================================================
module icache_direct_mapped #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    icache_direct_mapped_if.slave  cif
);
    localparam int c_OFF_W  = $clog2(LINE_WORDS);
    localparam int c_IDX_W  = $clog2(SETS);
    localparam int c_LINE_W = ADDR_W - c_OFF_W - 2;
    localparam int c_TAG_W  = c_LINE_W - c_IDX_W;

    localparam logic [c_OFF_W-1:0] c_LAST = c_OFF_W'(LINE_WORDS - 1);
    localparam logic [c_OFF_W-1:0] c_ONE  = c_OFF_W'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_FILL = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;
    localparam logic [1:0] c_ST_RESP = 2'd3;

    logic [DATA_W-1:0]   r_mem  [SETS][LINE_WORDS];
    logic [c_TAG_W-1:0]  r_tags [SETS];
    logic [SETS-1:0]     r_valid;

    logic [1:0]          r_state;
    logic                r_abort;
    logic [c_LINE_W-1:0] r_line;
    logic [c_OFF_W-1:0]  r_w;
    logic [c_OFF_W-1:0]  r_cnt;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rvalid;
    logic                r_arvalid;
    logic [ADDR_W-1:0]   r_araddr;
    logic [31:0]         r_hit_cnt;
    logic [31:0]         r_miss_cnt;

    logic [c_OFF_W-1:0]  w_off;
    logic [c_LINE_W-1:0] w_line;
    logic [c_IDX_W-1:0]  w_idx;
    logic [c_TAG_W-1:0]  w_tag;
    logic                w_hit;
    logic [c_IDX_W-1:0]  w_fill_idx;
    logic [c_OFF_W-1:0]  w_w_next;
    logic                w_fill_last;
    logic                w_fill_we;
    logic                w_unused_lsb;

    assign w_off        = cif.ifu_addr[c_OFF_W+1:2];
    assign w_line       = cif.ifu_addr[ADDR_W-1:c_OFF_W+2];
    assign w_idx        = w_line[c_IDX_W-1:0];
    assign w_tag        = w_line[c_LINE_W-1:c_IDX_W];
    assign w_hit        = r_valid[w_idx] && (r_tags[w_idx] == w_tag);
    assign w_fill_idx   = r_line[c_IDX_W-1:0];
    assign w_w_next     = r_w + c_ONE;
    assign w_fill_last  = (r_cnt == c_LAST);
    assign w_fill_we    = (r_state == c_ST_FILL) && cif.bus_rvalid && !cif.flush && !r_abort;
    assign w_unused_lsb = &{1'b0, cif.ifu_addr[1:0]};

    // Line storage has no reset; r_valid alone decides whether it is usable.
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_mem[w_fill_idx][r_w] <= cif.bus_rdata;
            if (w_fill_last) begin
                r_tags[w_fill_idx] <= r_line[c_LINE_W-1:c_IDX_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_valid    <= '0;
            r_abort    <= 1'b0;
            r_line     <= '0;
            r_w        <= '0;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_arvalid  <= 1'b0;
            r_araddr   <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (cif.flush) begin
                r_valid <= '0;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (!cif.flush && cif.ifu_req) begin
                        if (w_hit) begin
                            r_rdata   <= r_mem[w_idx][w_off];
                            r_rvalid  <= 1'b1;
                            r_hit_cnt <= r_hit_cnt + 32'd1;
                            r_state   <= c_ST_RESP;
                        end else begin
                            r_line         <= w_line;
                            r_w            <= w_off;
                            r_cnt          <= '0;
                            r_miss_cnt     <= r_miss_cnt + 32'd1;
                            r_valid[w_idx] <= 1'b0;
                            r_araddr       <= {w_line, w_off, 2'b00};
                            r_arvalid      <= 1'b1;
                            r_abort        <= 1'b0;
                            r_state        <= c_ST_FILL;
                        end
                    end
                end
                c_ST_FILL: begin
                    if (cif.bus_rvalid) begin
                        r_arvalid <= 1'b0;
                        if (cif.flush || r_abort) begin
                            // Outstanding read has drained; its data is dropped.
                            r_abort <= 1'b0;
                            r_state <= c_ST_IDLE;
                        end else begin
                            if (r_cnt == '0) begin
                                r_rdata <= cif.bus_rdata;
                            end
                            r_w   <= w_w_next;
                            r_cnt <= r_cnt + c_ONE;
                            if (w_fill_last) begin
                                r_valid[w_fill_idx] <= 1'b1;
                                r_rvalid            <= 1'b1;
                                r_state             <= c_ST_RESP;
                            end else begin
                                r_araddr <= {r_line, w_w_next, 2'b00};
                                r_state  <= c_ST_GAP;
                            end
                        end
                    end else if (cif.flush) begin
                        r_abort <= 1'b1;
                    end
                end
                c_ST_GAP: begin
                    if (cif.flush) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_arvalid <= 1'b1;
                        r_state   <= c_ST_FILL;
                    end
                end
                c_ST_RESP: begin
                    r_rvalid <= 1'b0;
                    r_state  <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign cif.ifu_rdata   = r_rdata;
    assign cif.ifu_rvalid  = r_rvalid;
    assign cif.bus_araddr  = r_araddr;
    assign cif.bus_arvalid = r_arvalid;
    assign cif.hit_cnt     = r_hit_cnt;
    assign cif.miss_cnt    = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_icache_direct_mapped.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_direct_mapped
// Purpose  : Scoreboard bench for icache_direct_mapped with a delaying bus model.
// Revision : 1.0
// ============================================================================
module tb_icache_direct_mapped;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    icache_direct_mapped_if #(.ADDR_W(32), .DATA_W(32)) cif ();

    icache_direct_mapped #(
        .ADDR_W(32), .DATA_W(32), .LINE_WORDS(4), .SETS(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cif(cif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    logic [31:0] exp_q [$];
    logic [31:0] log_addr [$];
    int          log_cyc [$];
    int          resp_cnt    = 0;
    int          cyc         = 0;
    int          rand_delay  = 0;
    int          fixed_delay = 1;

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: every ifu_rvalid consumes one scoreboard entry.
    initial begin
        forever begin
            @(negedge clk);
            if (cif.ifu_rvalid) begin
                resp_cnt++;
                check_eq("resp_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check_eq("resp_data", cif.ifu_rdata, exp_q.pop_front());
            end
        end
    end

    // Arbiter model: one read at a time, answered after 1..N cycles.
    initial begin
        logic [31:0] a;
        int          d;
        bit          aborted;
        cif.bus_rvalid = 1'b0;
        cif.bus_rdata  = '0;
        forever begin
            @(negedge clk);
            #1;
            cif.bus_rvalid = 1'b0;
            if (cif.bus_arvalid && !rst) begin
                a = cif.bus_araddr;
                log_addr.push_back(a);
                log_cyc.push_back(cyc);
                d = (rand_delay != 0) ? int'($urandom_range(1, 20)) : fixed_delay;
                aborted = 1'b0;
                for (int k = 1; k < d; k++) begin
                    @(negedge clk);
                    #1;
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    cif.bus_rdata  = mem_word(a);
                    cif.bus_rvalid = 1'b1;
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] a, output int lat);
        cif.ifu_addr = a;
        cif.ifu_req  = 1'b1;
        exp_q.push_back(mem_word(a));
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!cif.ifu_rvalid && lat < 2000);
        check_eq("fetch_done", 32'(cif.ifu_rvalid), 32'd1);
        cif.ifu_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          b;
        logic [31:0] pc;
        logic [31:0] exp_order [4];

        cif.ifu_addr = '0;
        cif.ifu_req  = 1'b0;
        cif.flush    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_eq("rst_rvalid",  32'(cif.ifu_rvalid),  32'd0);
        check_eq("rst_arvalid", 32'(cif.bus_arvalid), 32'd0);
        check_eq("rst_araddr",  cif.bus_araddr,       32'd0);
        check_eq("rst_rdata",   cif.ifu_rdata,        32'd0);
        check_eq("rst_hit",     cif.hit_cnt,          32'd0);
        check_eq("rst_miss",    cif.miss_cnt,         32'd0);

        // Cold miss: critical word first, wrapping, one idle cycle between reads.
        exp_order = '{32'h8000_0008, 32'h8000_000C, 32'h8000_0000, 32'h8000_0004};
        b = log_addr.size();
        fetch(32'h8000_0008, lat);
        check_eq("miss_latency", 32'(lat), 32'd8);
        check_eq("miss_cnt_1",   cif.miss_cnt, 32'd1);
        check_eq("miss_nreads",  32'(log_addr.size() - b), 32'd4);
        for (int i = 0; i < 4; i++) check_eq("refill_addr", log_addr[b+i], exp_order[i]);
        for (int i = 1; i < 4; i++) check_eq("refill_gap", 32'(log_cyc[b+i] - log_cyc[b+i-1]), 32'd2);

        // Hit in the freshly filled line.
        @(negedge clk);
        b = log_addr.size();
        fetch(32'h8000_0000, lat);
        check_eq("hit_latency", 32'(lat), 32'd1);
        check_eq("hit_nreads",  32'(log_addr.size() - b), 32'd0);
        check_eq("hit_cnt_1",   cif.hit_cnt, 32'd1);

        // Conflict on set 0.
        @(negedge clk);
        b = log_addr.size();
        fetch(32'h8000_0100, lat);
        fetch(32'h8000_0000, lat);
        check_eq("conflict_nreads", 32'(log_addr.size() - b), 32'd8);
        check_eq("conflict_miss",   cif.miss_cnt, 32'd3);
        check_eq("conflict_hit",    cif.hit_cnt,  32'd1);

        // Flush while the second refill read is outstanding.
        fixed_delay = 5;
        @(negedge clk);
        b = log_addr.size();
        cif.ifu_addr = 32'h8000_0040;
        cif.ifu_req  = 1'b1;
        exp_q.push_back(mem_word(32'h8000_0040));
        for (int k = 0; k < 200 && log_addr.size() < b + 2; k++) @(posedge clk);
        @(negedge clk);
        cif.flush = 1'b1;
        @(negedge clk);
        cif.flush = 1'b0;
        lat = 0;
        while (!cif.ifu_rvalid && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        check_eq("flush_done", 32'(cif.ifu_rvalid), 32'd1);
        cif.ifu_req = 1'b0;
        check_eq("flush_nreads", 32'(log_addr.size() - b), 32'd6);
        check_eq("flush_miss",   cif.miss_cnt, 32'd5);
        fixed_delay = 1;
        @(negedge clk);
        b = log_addr.size();
        fetch(32'h8000_0000, lat);
        check_eq("postflush_latency", 32'(lat), 32'd8);
        check_eq("postflush_nreads",  32'(log_addr.size() - b), 32'd4);
        check_eq("postflush_miss",    cif.miss_cnt, 32'd6);

        // Reset while the refill sits in GAP.
        @(negedge clk);
        b = log_addr.size();
        cif.ifu_addr = 32'h8000_0080;
        cif.ifu_req  = 1'b1;
        exp_q.push_back(mem_word(32'h8000_0080));
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (log_addr.size() == b + 1 && !cif.bus_arvalid) break;
        end
        check_eq("gap_reached", 32'(cif.bus_arvalid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_arvalid", 32'(cif.bus_arvalid), 32'd0);
        check_eq("midrst_rvalid",  32'(cif.ifu_rvalid),  32'd0);
        check_eq("midrst_hit",     cif.hit_cnt,          32'd0);
        check_eq("midrst_miss",    cif.miss_cnt,         32'd0);
        cif.ifu_req = 1'b0;
        exp_q.delete();
        rst = 1'b0;
        resp_cnt = 0;
        @(negedge clk);
        b = log_addr.size();
        fetch(32'h8000_0080, lat);
        check_eq("postrst_latency", 32'(lat), 32'd8);
        check_eq("postrst_nreads",  32'(log_addr.size() - b), 32'd4);
        check_eq("postrst_miss",    cif.miss_cnt, 32'd1);
        check_eq("postrst_hit",     cif.hit_cnt,  32'd0);

        // Random bus latency, mostly sequential fetches with occasional jumps.
        rand_delay = 1;
        pc = 32'h8000_0000;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) pc = 32'h8000_0000 | ($urandom_range(0, 255) << 2);
            else                           pc = 32'h8000_0000 | ((pc + 32'd4) & 32'h0000_03FC);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            fetch(pc, lat);
        end
        @(negedge clk);
        check_eq("rand_resp_cnt", 32'(resp_cnt), 32'd1501);
        check_eq("rand_cnt_sum",  cif.hit_cnt + cif.miss_cnt, 32'(resp_cnt));
        check_eq("rand_q_empty",  32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
